islem_planlayici: RTL and testbench

- Upstream planning stage for the car-wash station accounting block. It buffers daily operation requests from the operator interface in a small FIFO and presents exactly one 2-bit operation code per clock, where one clock is one business day.
- It enforces the station's wash-day rule: the day after a 2'b10 is forced to 2'b00 without consuming a request, so no queued request is lost.
- It also tracks the day number and flags end of month.

---
 rtl/islem_planlayici.sv | 144 ++++++++++++++
 tb/tb_islem_planlayici.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/islem_planlayici.sv
// Car-wash planning stage: request FIFO, one operation code per business day,
// wash-day lockout, day/month tracking. Optional per-code counters: ISLEM_SAYAC_EN.
module islem_planlayici #(
   parameter int         DERINLIK         = 4,
   parameter logic [1:0] VARSAYILAN_ISLEM = 2'b01,
   parameter int         AY_UZUNLUGU      = 30
) (
   input  logic                        saat,
   input  logic                        reset,
   input  logic                        istek_gecerli,
   input  logic [1:0]                  istek_islem,
   output logic                        istek_hazir,
   output logic [1:0]                  islem,
   output logic [4:0]                  gun_no,
   output logic                        ay_bitti,
   output logic [$clog2(DERINLIK):0]   doluluk,
   output logic [4:0]                  bos_gun
`ifdef ISLEM_SAYAC_EN
   ,
   output logic [4:0]                  sayac_00,
   output logic [4:0]                  sayac_01,
   output logic [4:0]                  sayac_10,
   output logic [4:0]                  sayac_11
`endif
);

   localparam int          AW     = $clog2(DERINLIK);
   localparam logic [AW:0] DOLU   = DERINLIK[AW:0];
   localparam logic [AW:0] BIR_D  = 1;
   localparam logic [4:0]  AY_SON = AY_UZUNLUGU[4:0];

   // GUN_KILIT is the forced 2'b00 day after a wash day; GUN_BITTI absorbs until reset.
   typedef enum logic [1:0] {GUN_NORMAL, GUN_KILIT, GUN_BITTI} durum_t;

   durum_t           durum_q, durum_d;
   logic [1:0]       mem_q [DERINLIK];
   logic [1:0]       mem_d [DERINLIK];
   logic [AW-1:0]    oku_ptr_q, oku_ptr_d;
   logic [AW-1:0]    yaz_ptr_q, yaz_ptr_d;
   logic [AW:0]      doluluk_q, doluluk_d;
   logic [4:0]       gun_no_q, gun_no_d;
   logic [4:0]       bos_gun_q, bos_gun_d;

   logic             kilit, fifo_bos, yaz, oku;

`ifdef ISLEM_SAYAC_EN
   logic [4:0] sayac_q [4];
   logic [4:0] sayac_d [4];
`endif

   always_comb begin
      kilit       = (durum_q == GUN_KILIT);
      ay_bitti    = (durum_q == GUN_BITTI);
      fifo_bos    = (doluluk_q == '0);
      istek_hazir = (doluluk_q != DOLU);

      if (ay_bitti)      islem = 2'b01;
      else if (kilit)    islem = 2'b00;
      else if (fifo_bos) islem = VARSAYILAN_ISLEM;
      else               islem = mem_q[oku_ptr_q];

      yaz = istek_gecerli && istek_hazir;
      oku = !ay_bitti && !kilit && !fifo_bos;

      mem_d     = mem_q;
      oku_ptr_d = oku_ptr_q;
      yaz_ptr_d = yaz_ptr_q;
      doluluk_d = doluluk_q;
      durum_d   = durum_q;
      gun_no_d  = gun_no_q;
      bos_gun_d = bos_gun_q;

      if (yaz) begin
         mem_d[yaz_ptr_q] = istek_islem;
         yaz_ptr_d        = yaz_ptr_q + AW'(1);
      end
      if (oku) oku_ptr_d = oku_ptr_q + AW'(1);

      case ({yaz, oku})
         2'b10:   doluluk_d = doluluk_q + BIR_D;
         2'b01:   doluluk_d = doluluk_q - BIR_D;
         default: doluluk_d = doluluk_q;
      endcase

      case (durum_q)
         GUN_NORMAL: begin
            if (gun_no_q == AY_SON)    durum_d = GUN_BITTI;
            else if (islem == 2'b10)   durum_d = GUN_KILIT;
         end
         GUN_KILIT: begin
            if (gun_no_q == AY_SON)    durum_d = GUN_BITTI;
            else                       durum_d = GUN_NORMAL;
         end
         default:                      durum_d = GUN_BITTI;
      endcase

      if (!ay_bitti) gun_no_d = gun_no_q + 5'd1;

      if (!ay_bitti && !kilit && fifo_bos && (bos_gun_q < 5'd30))
         bos_gun_d = bos_gun_q + 5'd1;
   end

`ifdef ISLEM_SAYAC_EN
   always_comb begin
      sayac_d = sayac_q;
      if (!ay_bitti) sayac_d[islem] = sayac_q[islem] + 5'd1;
   end

   always_ff @(posedge saat or posedge reset) begin
      if (reset) sayac_q <= '{default: '0};
      else       sayac_q <= sayac_d;
   end

   assign sayac_00 = sayac_q[0];
   assign sayac_01 = sayac_q[1];
   assign sayac_10 = sayac_q[2];
   assign sayac_11 = sayac_q[3];
`endif

   always_ff @(posedge saat or posedge reset) begin
      if (reset) begin
         durum_q   <= GUN_NORMAL;
         mem_q     <= '{default: '0};
         oku_ptr_q <= '0;
         yaz_ptr_q <= '0;
         doluluk_q <= '0;
         gun_no_q  <= 5'd1;
         bos_gun_q <= '0;
      end else begin
         durum_q   <= durum_d;
         mem_q     <= mem_d;
         oku_ptr_q <= oku_ptr_d;
         yaz_ptr_q <= yaz_ptr_d;
         doluluk_q <= doluluk_d;
         gun_no_q  <= gun_no_d;
         bos_gun_q <= bos_gun_d;
      end
   end

   assign gun_no  = gun_no_q;
   assign doluluk = doluluk_q;
   assign bos_gun = bos_gun_q;

endmodule

// File: tb/tb_islem_planlayici.sv
// Directed scoreboard bench for islem_planlayici: stimulus queues expected
// per-day state, a monitor pops and compares once per day.
module tb_islem_planlayici;

   logic       saat = 1'b0;
   logic       reset = 1'b1;
   logic       istek_gecerli = 1'b0;
   logic [1:0] istek_islem = 2'b00;
   logic       istek_hazir;
   logic [1:0] islem;
   logic [4:0] gun_no;
   logic       ay_bitti;
   logic [2:0] doluluk;
   logic [4:0] bos_gun;
`ifdef ISLEM_SAYAC_EN
   logic [4:0] sayac_00, sayac_01, sayac_10, sayac_11;
`endif

   islem_planlayici #(
      .DERINLIK(4),
      .VARSAYILAN_ISLEM(2'b01),
      .AY_UZUNLUGU(30)
   ) dut (
      .saat(saat),
      .reset(reset),
      .istek_gecerli(istek_gecerli),
      .istek_islem(istek_islem),
      .istek_hazir(istek_hazir),
      .islem(islem),
      .gun_no(gun_no),
      .ay_bitti(ay_bitti),
      .doluluk(doluluk),
      .bos_gun(bos_gun)
`ifdef ISLEM_SAYAC_EN
      ,
      .sayac_00(sayac_00),
      .sayac_01(sayac_01),
      .sayac_10(sayac_10),
      .sayac_11(sayac_11)
`endif
   );

   always #5 saat = ~saat;

   typedef struct {
      int etiket;
      int islem;
      int dol;
      int gun;
      int bitti;
      int hazir;
      int bos;
   } bekl_t;

   bekl_t bekl_q[$];
   int    toplam = 0;
   int    hata   = 0;
   int    adim   = 0;

   task automatic kontrol(input string ad, input int etiket, input int gercek, input int beklenen);
      toplam++;
      if (gercek != beklenen) begin
         hata++;
         $display("FAIL %s (adim %0d): gercek=%0d beklenen=%0d", ad, etiket, gercek, beklenen);
      end
   endtask

   // Called at a falling edge: drive this day's request, queue the expected
   // visible state of the current day, then let the day's rising edge pass.
   task automatic gun(input logic v, input logic [1:0] op, input int e_islem, input int e_dol,
                      input int e_gun, input int e_bitti, input int e_bos);
      bekl_t b;
      istek_gecerli = v;
      istek_islem   = op;
      adim++;
      b = '{adim, e_islem, e_dol, e_gun, e_bitti, (e_dol != 4) ? 1 : 0, e_bos};
      bekl_q.push_back(b);
      @(negedge saat);
   endtask

   task automatic sifirla();
      bekl_t b;
      reset         = 1'b1;
      istek_gecerli = 1'b0;
      adim++;
      b = '{adim, 1, 0, 1, 0, 1, 0};
      bekl_q.push_back(b);
      @(negedge saat);
      reset = 1'b0;
   endtask

   initial begin
      bekl_t b;
      forever begin
         @(negedge saat);
         #2;
         if (bekl_q.size() != 0) begin
            b = bekl_q.pop_front();
            kontrol("islem",       b.etiket, int'(islem),       b.islem);
            kontrol("doluluk",     b.etiket, int'(doluluk),     b.dol);
            kontrol("gun_no",      b.etiket, int'(gun_no),      b.gun);
            kontrol("ay_bitti",    b.etiket, int'(ay_bitti),    b.bitti);
            kontrol("istek_hazir", b.etiket, int'(istek_hazir), b.hazir);
            kontrol("bos_gun",     b.etiket, int'(bos_gun),     b.bos);
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL zaman_asimi: gercek=asildi beklenen=bitis");
      $fatal(1, "zaman asimi");
   end

   initial begin
      @(negedge saat);

      // Empty month: default every day, then month end holds.
      sifirla();
      for (int d = 1; d <= 30; d++) gun(1'b0, 2'b00, 1, 0, d, 0, d - 1);
      gun(1'b1, 2'b10, 1, 0, 31, 1, 30);
      gun(1'b0, 2'b00, 1, 1, 31, 1, 30);
      gun(1'b0, 2'b00, 1, 1, 31, 1, 30);

      // Mid-month reset with three queued entries and lock active.
      sifirla();
      for (int d = 1; d <= 6; d++) gun(1'b0, 2'b00, 1, 0, d, 0, d - 1);
      gun(1'b1, 2'b10, 1, 0, 7,  0, 6);
      gun(1'b1, 2'b10, 2, 1, 8,  0, 7);
      gun(1'b1, 2'b10, 0, 1, 9,  0, 7);
      gun(1'b1, 2'b10, 2, 2, 10, 0, 7);
      gun(1'b1, 2'b11, 0, 2, 11, 0, 7);
      gun(1'b1, 2'b01, 2, 3, 12, 0, 7);
      sifirla();

      // 10 then 11: wash day, forced 00 without pop, then 11, then default.
      gun(1'b1, 2'b10, 1, 0, 1, 0, 0);
      gun(1'b1, 2'b11, 2, 1, 2, 0, 1);
      gun(1'b0, 2'b00, 0, 1, 3, 0, 1);
      gun(1'b0, 2'b00, 3, 1, 4, 0, 1);
      gun(1'b0, 2'b00, 1, 0, 5, 0, 1);

      // Back-to-back 10s fill the FIFO during lock days; full refuses a push.
      gun(1'b1, 2'b10, 1, 0, 6,  0, 2);
      gun(1'b1, 2'b10, 2, 1, 7,  0, 3);
      gun(1'b1, 2'b10, 0, 1, 8,  0, 3);
      gun(1'b1, 2'b10, 2, 2, 9,  0, 3);
      gun(1'b1, 2'b11, 0, 2, 10, 0, 3);
      gun(1'b1, 2'b11, 2, 3, 11, 0, 3);
      gun(1'b1, 2'b11, 0, 3, 12, 0, 3);
      gun(1'b1, 2'b00, 2, 4, 13, 0, 3);
      gun(1'b1, 2'b01, 0, 3, 14, 0, 3);
      gun(1'b0, 2'b00, 3, 4, 15, 0, 3);
      gun(1'b0, 2'b00, 3, 3, 16, 0, 3);
      gun(1'b0, 2'b00, 3, 2, 17, 0, 3);
      gun(1'b0, 2'b00, 1, 1, 18, 0, 3);
      gun(1'b0, 2'b00, 1, 0, 19, 0, 3);
      gun(1'b0, 2'b00, 1, 0, 20, 0, 4);

      // Simultaneous push and pop at occupancy 2 keeps order.
      sifirla();
      gun(1'b1, 2'b10, 1, 0, 1, 0, 0);
      gun(1'b1, 2'b11, 2, 1, 2, 0, 1);
      gun(1'b1, 2'b00, 0, 1, 3, 0, 1);
      gun(1'b1, 2'b11, 3, 2, 4, 0, 1);
      gun(1'b0, 2'b00, 0, 2, 5, 0, 1);
      gun(1'b0, 2'b00, 3, 1, 6, 0, 1);
      gun(1'b0, 2'b00, 1, 0, 7, 0, 1);
      gun(1'b0, 2'b00, 1, 0, 8, 0, 2);

      #3;
      kontrol("kuyruk_bos", adim, bekl_q.size(), 0);
      $display("test done: total=%0d bad=%0d", toplam, hata);
      $finish;
   end

endmodule
